// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the IF/ID register.
//   - default address/data widths used across pipeline stages
//   - PC increment and NOP encoding
//   - fetch FSM state encoding
package fetch_stage_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned PC_INC     = 4;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_BUF  = 3'd3,
      S_DROP = 3'd4
   } fetch_state_e;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush > freeze > load priority.
// Ports:
//   clk, rst_n            clock, asynchronous active-low clear
//   flush                 drop the held instruction (valid <= 0)
//   freeze                hold all fields
//   load                  capture load_pc / load_instr as a live instruction
//   valid, pc, instr      registered IF/ID contents
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              freeze,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_pc,
   input  logic [DATA_W-1:0] load_instr,
   output logic              valid,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instr
);

   // Data fields only change on a real load; flush and bubbles clear valid alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= DATA_W'(NOP_INSTR);
      end else if (flush) begin
         valid <= 1'b0;
      end else if (freeze) begin
         valid <= valid;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= load_pc;
         instr <= load_instr;
      end else begin
         valid <= 1'b0;
      end
   end

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time to a variable-latency instruction memory, parks a response that lands
// during freeze in a one-entry buffer, and squashes in-flight fetches on a
// redirect from EXE.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   freeze                          hazard stall, IF/ID holds
//   branch_taken, branch_addr       redirect request and target (bits [1:0] ignored)
//   imem_req, imem_addr             fetch request (decoded from state) and aligned address
//   imem_gnt                        request accepted this cycle
//   imem_rvalid, imem_rdata         fetch response
//   if_id_valid, if_id_pc, if_id_instr  IF/ID register (pc = fetch PC + 4)
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEF,
   parameter int unsigned       DATA_W   = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_id_valid,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [DATA_W-1:0] if_id_instr
);

   fetch_state_e      state, state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_pc;
   logic              buf_valid;
   logic [ADDR_W-1:0] buf_pc;
   logic [DATA_W-1:0] buf_instr;

   logic              grant_c;
   logic              capture_c;
   logic              if_load_c;
   logic              use_buf_c;
   logic [ADDR_W-1:0] if_load_pc_c;
   logic [DATA_W-1:0] if_load_instr_c;
   logic [ADDR_W-1:0] branch_aligned_c;
   logic              unused_addr_lsb;

   assign branch_aligned_c = {branch_addr[ADDR_W-1:2], 2'b00};
   assign imem_addr        = {pc[ADDR_W-1:2], 2'b00};
   assign unused_addr_lsb  = ^{branch_addr[1:0], pc[1:0]};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; redirect overrides freeze everywhere
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: state_nxt = S_REQ;
         S_REQ: begin
            // A grant coinciding with a redirect fetched the stale PC
            if (imem_gnt) state_nxt = branch_taken ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (branch_taken)     state_nxt = imem_rvalid ? S_REQ : S_DROP;
            else if (imem_rvalid) state_nxt = freeze ? S_BUF : S_REQ;
         end
         S_BUF: begin
            if (branch_taken || !freeze) state_nxt = S_REQ;
         end
         S_DROP: begin
            if (imem_rvalid) state_nxt = S_REQ;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      imem_req  = 1'b0;
      grant_c   = 1'b0;
      capture_c = 1'b0;
      if_load_c = 1'b0;
      use_buf_c = 1'b0;
      unique case (state)
         S_REQ: begin
            imem_req = 1'b1;
            grant_c  = imem_gnt;
         end
         S_WAIT: begin
            capture_c = imem_rvalid && freeze && !branch_taken;
            if_load_c = imem_rvalid && !freeze && !branch_taken;
         end
         S_BUF: begin
            use_buf_c = 1'b1;
            if_load_c = buf_valid && !freeze && !branch_taken;
         end
         default: ;
      endcase
   end

   assign if_load_pc_c    = use_buf_c ? buf_pc    : req_pc + ADDR_W'(PC_INC);
   assign if_load_instr_c = use_buf_c ? buf_instr : imem_rdata;

   // PC, in-flight fetch PC and the one-entry freeze buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= {RESET_PC[ADDR_W-1:2], 2'b00};
         req_pc    <= '0;
         buf_valid <= 1'b0;
         buf_pc    <= '0;
         buf_instr <= DATA_W'(NOP_INSTR);
      end else begin
         if (branch_taken) pc <= branch_aligned_c;
         else if (grant_c) pc <= pc + ADDR_W'(PC_INC);

         if (grant_c) req_pc <= pc;

         if (branch_taken) begin
            buf_valid <= 1'b0;
         end else if (capture_c) begin
            buf_valid <= 1'b1;
            buf_pc    <= req_pc + ADDR_W'(PC_INC);
            buf_instr <= imem_rdata;
         end else if (if_load_c && use_buf_c) begin
            buf_valid <= 1'b0;
         end
      end
   end

   if_id_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_if_id_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (branch_taken),
      .freeze     (freeze),
      .load       (if_load_c),
      .load_pc    (if_load_pc_c),
      .load_instr (if_load_instr_c),
      .valid      (if_id_valid),
      .pc         (if_id_pc),
      .instr      (if_id_instr)
   );

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory handshake is driven step by step
// and every expected value is hand-computed.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;

   int n_pass  = 0;
   int n_total = 0;

   fetch_stage #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .if_id_valid  (if_id_valid),
      .if_id_pc     (if_id_pc),
      .if_id_instr  (if_id_instr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   initial begin
      rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      #3;
      chk("rst_req",   32'(imem_req),    32'h0);
      chk("rst_valid", 32'(if_id_valid), 32'h0);
      chk("rst_pc",    if_id_pc,         32'h0);
      chk("rst_instr", if_id_instr,      32'h0);
      tick(); tick();
      rst_n = 1'b1; imem_gnt = 1'b1;

      // Back-to-back fetches with one-cycle response latency
      tick();                                            // IDLE -> REQ
      chk("first_req",  32'(imem_req), 32'h1);
      chk("first_addr", imem_addr,     32'h0);
      tick();                                            // granted -> WAIT
      chk("wait_req", 32'(imem_req), 32'h0);
      imem_rvalid = 1'b1; imem_rdata = 32'hE3A01001;
      tick();                                            // load
      imem_rvalid = 1'b0;
      chk("i0_valid", 32'(if_id_valid), 32'h1);
      chk("i0_pc",    if_id_pc,         32'h4);
      chk("i0_instr", if_id_instr,      32'hE3A01001);
      chk("i0_addr",  imem_addr,        32'h4);
      tick();                                            // REQ -> WAIT, bubble
      chk("bubble_valid", 32'(if_id_valid), 32'h0);
      imem_rvalid = 1'b1; imem_rdata = 32'hE3A02002;
      tick();
      imem_rvalid = 1'b0;
      chk("i1_valid", 32'(if_id_valid), 32'h1);
      chk("i1_pc",    if_id_pc,         32'h8);
      chk("i1_instr", if_id_instr,      32'hE3A02002);

      // Response during freeze parks in the buffer
      tick();                                            // REQ -> WAIT (pc 0xC)
      freeze = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hE0811002;
      tick();                                            // -> BUF
      imem_rvalid = 1'b0;
      chk("frz_state", 32'(dut.state),   32'(S_BUF));
      chk("frz_req",   32'(imem_req),    32'h0);
      chk("frz_instr", if_id_instr,      32'hE3A02002);
      chk("frz_valid", 32'(if_id_valid), 32'h0);
      tick();
      chk("frz2_req", 32'(imem_req), 32'h0);
      tick();
      freeze = 1'b0;
      tick();                                            // unload buffer
      chk("unfrz_instr", if_id_instr,      32'hE0811002);
      chk("unfrz_pc",    if_id_pc,         32'hC);
      chk("unfrz_valid", 32'(if_id_valid), 32'h1);
      chk("unfrz_req",   32'(imem_req),    32'h1);
      chk("unfrz_addr",  imem_addr,        32'hC);

      // Redirect while waiting: the late response is dropped
      tick();                                            // REQ -> WAIT
      branch_taken = 1'b1; branch_addr = 32'h103; imem_gnt = 1'b0;
      tick();                                            // -> DROP
      branch_taken = 1'b0;
      chk("br_wait_valid", 32'(if_id_valid), 32'h0);
      chk("br_wait_state", 32'(dut.state),   32'(S_DROP));
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
      tick();                                            // DROP -> REQ
      imem_rvalid = 1'b0;
      chk("drop_valid", 32'(if_id_valid), 32'h0);
      chk("drop_req",   32'(imem_req),    32'h1);
      chk("drop_addr",  imem_addr,        32'h100);

      // Redirect coinciding with grant
      branch_taken = 1'b1; branch_addr = 32'h20;
      tick();                                            // REQ stays, pc 0x20
      chk("redir_addr", imem_addr, 32'h20);
      branch_addr = 32'h80; imem_gnt = 1'b1;
      tick();                                            // -> DROP
      branch_taken = 1'b0;
      chk("gntbr_state", 32'(dut.state), 32'(S_DROP));
      chk("gntbr_req",   32'(imem_req),  32'h0);
      imem_rvalid = 1'b1; imem_rdata = 32'hBADBAD00;
      tick();                                            // DROP -> REQ
      imem_rvalid = 1'b0;
      chk("gntbr_addr",  imem_addr,        32'h80);
      chk("gntbr_valid", 32'(if_id_valid), 32'h0);

      // Redirect plus freeze while buffered
      tick();                                            // REQ -> WAIT (0x80)
      imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
      tick();                                            // load
      imem_rvalid = 1'b0; freeze = 1'b1;
      chk("pre_buf_pc", if_id_pc, 32'h84);
      tick();                                            // REQ -> WAIT (0x84)
      imem_rvalid = 1'b1; imem_rdata = 32'h22222222;
      tick();                                            // -> BUF
      imem_rvalid = 1'b0;
      chk("buf_hold_valid", 32'(if_id_valid), 32'h1);
      chk("buf_state",      32'(dut.state),   32'(S_BUF));
      branch_taken = 1'b1; branch_addr = 32'h200; imem_gnt = 1'b0;
      tick();
      branch_taken = 1'b0; freeze = 1'b0;
      chk("bufbr_valid", 32'(if_id_valid),   32'h0);
      chk("bufbr_empty", 32'(dut.buf_valid), 32'h0);
      chk("bufbr_req",   32'(imem_req),      32'h1);
      chk("bufbr_addr",  imem_addr,          32'h200);

      // PC wrap at the top of the address space
      branch_taken = 1'b1; branch_addr = 32'hFFFFFFFC;
      tick();
      branch_taken = 1'b0; imem_gnt = 1'b1;
      chk("wrap_pre_addr", imem_addr, 32'hFFFFFFFC);
      tick();                                            // granted
      imem_rvalid = 1'b1; imem_rdata = 32'h33333333;
      tick();
      imem_rvalid = 1'b0;
      chk("wrap_addr",  imem_addr,        32'h0);
      chk("wrap_ifpc",  if_id_pc,         32'h0);
      chk("wrap_valid", 32'(if_id_valid), 32'h1);

      // Asynchronous reset while in WAIT
      tick();                                            // REQ -> WAIT
      #2 rst_n = 1'b0;
      #1;
      chk("arst_instr", if_id_instr,      32'h0);
      chk("arst_valid", 32'(if_id_valid), 32'h0);
      chk("arst_state", 32'(dut.state),   32'(S_IDLE));
      chk("arst_req",   32'(imem_req),    32'h0);
      tick();
      rst_n = 1'b1;
      tick();                                            // IDLE -> REQ
      chk("post_rst_req",  32'(imem_req), 32'h1);
      chk("post_rst_addr", imem_addr,     32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_fetch_stage
